// File: rtl/img_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// img_ctrl_pkg
//   Shared constants for the image-control front panel.
//   - BTN_SELECT_MODE / BTN_THRESHOLD : bit indices of the button vector
//     (o_press[BTN_SELECT_MODE] feeds i_select_mode,
//      o_press[BTN_THRESHOLD]   feeds i_threshold).
//   - DEBOUNCE_CYCLES_DEFAULT         : stable-cycle window for the board clock
//     (10 ms at 50 MHz).
// -----------------------------------------------------------------------------
package img_ctrl_pkg;

    localparam int BTN_SELECT_MODE         = 0;
    localparam int BTN_THRESHOLD           = 1;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage : img_ctrl_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button bit: 2-flop synchroniser, polarity normalisation, stable-window
//   counter, accepted-level register and registered press/release pulses.
// Ports
//   i_clk       in  1  system clock, rising-edge
//   i_reset_n   in  1  asynchronous, active-low reset
//   btn_raw_i   in  1  raw pin, asynchronous to i_clk, may bounce
//   level_o     out 1  debounced level, 1 = pressed
//   press_o     out 1  1-cycle pulse on accepted released->pressed transition
//   release_o   out 1  1-cycle pulse on accepted pressed->released transition
// -----------------------------------------------------------------------------
module debounce_channel
    import img_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level that means "not pressed" for this board polarity.
    localparam logic             RELEASED_PIN = ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // NOTE: the synchroniser resets to the released pin level, not to 0, so an
    // idle active-low button does not look like a fresh press after reset.
    // NOTE: every sequential assignment is non-blocking so all flops sample
    // pre-edge values; blocking here would collapse sync1->sync2 into one stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= RELEASED_PIN;
            sync2_q <= RELEASED_PIN;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Normalised sample: 1 = pressed regardless of pin polarity.
    assign s = sync2_q ^ ACTIVE_LOW;

    // NOTE: every next-state signal gets a default at the top of the block so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d     = '0;
        stable_d  = stable_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                // Window complete: accept the new level and emit one pulse.
                stable_d  = s;
                press_d   = s;
                release_d = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // s == stable_q: any agreeing cycle discards the partial count.
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Turns raw, bouncing board push-buttons into clean debounced levels and
//   single-cycle press/release pulses. Channels are fully independent.
// Ports
//   i_clk      in  1          system clock, rising-edge
//   i_reset_n  in  1          asynchronous, active-low reset
//   i_btn_raw  in  N_BUTTONS  raw button pins, asynchronous, may bounce
//   o_level    out N_BUTTONS  debounced level, 1 = pressed
//   o_press    out N_BUTTONS  1-cycle pulse on accepted press
//   o_release  out N_BUTTONS  1-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module button_conditioner
    import img_ctrl_pkg::*;
#(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [N_BUTTONS-1:0] i_btn_raw,
    output logic [N_BUTTONS-1:0] o_level,
    output logic [N_BUTTONS-1:0] o_press,
    output logic [N_BUTTONS-1:0] o_release
);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .btn_raw_i (i_btn_raw[g]),
            .level_o   (o_level[g]),
            .press_o   (o_press[g]),
            .release_o (o_release[g])
        );
    end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed stimulus with a scoreboard: each stimulus step that should cause a
//   pulse pushes the expected edge number and pulse/level values; a monitor
//   on the falling edge pops and compares whenever a pulse appears, and flags
//   pulses nobody expected or expected pulses that never came.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int DC = 4;
    // Pin change to pulse: DEBOUNCE_CYCLES + 2 edges.
    localparam int LAT = DC + 2;

    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic [N-1:0] i_btn_raw = '1;
    logic [N-1:0] o_level, o_press, o_release;

    button_conditioner #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn_raw (i_btn_raw),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] level;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Rising edges seen so far; read on the falling edge.
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    // Drive pins on a falling edge; optionally schedule the expected pulse.
    task automatic drive(input logic [N-1:0] pins, input bit evt,
                         input logic [N-1:0] press, input logic [N-1:0] rel,
                         input logic [N-1:0] level);
        exp_t e;
        @(negedge i_clk);
        i_btn_raw = pins;
        if (evt) begin
            e.cyc = cyc + LAT; e.press = press; e.rel = rel; e.level = level;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Monitor / scoreboard.
    always @(negedge i_clk) begin
        exp_t e;
        if ((o_press | o_release) != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'({o_press, o_release}), 0);
            end else begin
                e = sb.pop_front();
                check("pulse_edge",  cyc, e.cyc);
                check("pulse_press", int'(o_press), int'(e.press));
                check("pulse_rel",   int'(o_release), int'(e.rel));
                check("pulse_level", int'(o_level), int'(e.level));
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check("missing_pulse", cyc, e.cyc);
        end
    end

    initial begin
        // 1. Reset with both buttons released, then idle.
        idle(3);
        check("rst_out", int'({o_level, o_press, o_release}), 0);
        i_reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            check("idle_out", int'({o_level, o_press, o_release}), 0);
        end

        // 2. Press pin0 and hold for 100 cycles: one pulse, no repeat.
        drive(2'b10, 1'b1, 2'b01, 2'b00, 2'b01);
        idle(100);
        check("hold_level", int'(o_level), 1);
        drive(2'b11, 1'b1, 2'b00, 2'b01, 2'b00);
        idle(10);
        check("rel_level", int'(o_level), 0);

        // 3. Bounce 0,1,0,1 then settle at 0: pulse counted from the settle.
        drive(2'b10, 1'b0, '0, '0, '0);
        drive(2'b11, 1'b0, '0, '0, '0);
        drive(2'b10, 1'b0, '0, '0, '0);
        drive(2'b11, 1'b0, '0, '0, '0);
        drive(2'b10, 1'b1, 2'b01, 2'b00, 2'b01);
        idle(12);
        check("bounce_level", int'(o_level), 1);
        drive(2'b11, 1'b1, 2'b00, 2'b01, 2'b00);
        idle(10);

        // 4. Pin0 low for only 3 cycles: rejected.
        drive(2'b10, 1'b0, '0, '0, '0);
        idle(2);
        drive(2'b11, 1'b0, '0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check("short_level", int'(o_level), 0);
        end

        // 5. Both pins together: simultaneous press, then simultaneous release.
        drive(2'b00, 1'b1, 2'b11, 2'b00, 2'b11);
        idle(10);
        check("both_level", int'(o_level), 3);
        drive(2'b11, 1'b1, 2'b00, 2'b11, 2'b00);
        idle(10);
        check("both_rel_level", int'(o_level), 0);

        // 6. Pin1 low, reset mid-debounce: full window restarts after reset.
        drive(2'b01, 1'b0, '0, '0, '0);
        idle(2);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        idle(1);
        check("midrst_out", int'({o_level, o_press, o_release}), 0);
        idle(2);
        check("midrst_out2", int'({o_level, o_press, o_release}), 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        begin
            exp_t e;
            e.cyc = cyc + LAT; e.press = 2'b10; e.rel = 2'b00; e.level = 2'b10;
            sb.push_back(e);
        end
        idle(LAT - 1);
        check("post_rst_level_early", int'(o_level), 0);
        idle(5);
        check("post_rst_level", int'(o_level), 2);

        idle(5);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_button_conditioner
